// File: rtl/framebuffer_arbiter_if.sv
// Port bundle between the framebuffer arbiter, its three clients and the single-port RAM.
// The arbiter connects to the slave modport; the environment drives the master modport.
interface framebuffer_arbiter_if;
  logic        vid_req;
  logic [18:0] vid_address;
  logic        vid_ack;
  logic [2:0]  vid_data;
  logic        vid_valid;

  logic        gl_req;
  logic        gl_write_enabled;
  logic [18:0] gl_address;
  logic [2:0]  gl_write_data;
  logic        gl_ready;
  logic [2:0]  gl_read_data;
  logic        gl_read_valid;

  logic        clear_start;
  logic [2:0]  clear_color;
  logic        clear_busy;
  logic        clear_done;

  logic [18:0] ram_address;
  logic        ram_write_enabled;
  logic [2:0]  ram_write_data;
  logic [2:0]  ram_read_data;

  modport slave (
    input  vid_req, vid_address, gl_req, gl_write_enabled, gl_address, gl_write_data,
           clear_start, clear_color, ram_read_data,
    output vid_ack, vid_data, vid_valid, gl_ready, gl_read_data, gl_read_valid,
           clear_busy, clear_done, ram_address, ram_write_enabled, ram_write_data
  );

  modport master (
    output vid_req, vid_address, gl_req, gl_write_enabled, gl_address, gl_write_data,
           clear_start, clear_color, ram_read_data,
    input  vid_ack, vid_data, vid_valid, gl_ready, gl_read_data, gl_read_valid,
           clear_busy, clear_done, ram_address, ram_write_enabled, ram_write_data
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Shares the single-port framebuffer RAM between video scanout, game logic and a clear engine.
// Video has priority, bounded by a streak limit; reads return to their issuer two cycles later.
module framebuffer_arbiter #(
  parameter int unsigned PIXELS           = 76800,
  parameter int unsigned MAX_VIDEO_STREAK = 3
) (
  input logic                  clock,
  input logic                  reset,
  framebuffer_arbiter_if.slave bus
);

  localparam int unsigned CntW    = $clog2(PIXELS);
  localparam int unsigned StreakW = $clog2(MAX_VIDEO_STREAK + 1);

  localparam logic [18:0]        PixLimit  = 19'(PIXELS);
  localparam logic [CntW-1:0]    LastCnt   = CntW'(PIXELS - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_VIDEO_STREAK);

  typedef enum logic [0:0] {StIdle, StClear} state_e;
  typedef enum logic [1:0] {TagNone, TagVid, TagGl} tag_e;

  state_e              state_q, state_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          color_q, color_d;
  logic                done_q, done_d;
  logic [18:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [2:0]          wd_q, wd_d;
  tag_e                tag1_q, tag1_d, tag2_q;
  logic                oor1_q, oor1_d, oor2_q;

  logic other_pend, vid_win, gl_win, clr_win;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      streak_q <= '0;
      cnt_q    <= '0;
      color_q  <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wd_q     <= '0;
      tag1_q   <= TagNone;
      tag2_q   <= TagNone;
      oor1_q   <= 1'b0;
      oor2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
      color_q  <= color_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wd_q     <= wd_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag1_q;
      oor1_q   <= oor1_d;
      oor2_q   <= oor1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = '0;
    cnt_d    = cnt_q;
    color_d  = color_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wd_d     = wd_q;
    tag1_d   = TagNone;
    oor1_d   = 1'b0;

    // In CLEAR the clear engine always has a write waiting.
    other_pend = (state_q == StClear) || bus.gl_req;
    // Grants are gated by reset so the combinational acks read 0 while reset is held.
    vid_win = reset && bus.vid_req && !((streak_q == StreakMax) && other_pend);
    gl_win  = reset && (state_q == StIdle) && bus.gl_req && !vid_win;
    clr_win = reset && (state_q == StClear) && !vid_win;

    if (vid_win && other_pend) begin
      streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
    end

    if (vid_win) begin
      addr_d = bus.vid_address;
      tag1_d = TagVid;
      oor1_d = (bus.vid_address >= PixLimit);
    end else if (gl_win) begin
      addr_d = bus.gl_address;
      wd_d   = bus.gl_write_data;
      if (bus.gl_write_enabled) begin
        we_d = (bus.gl_address < PixLimit);
      end else begin
        tag1_d = TagGl;
        oor1_d = (bus.gl_address >= PixLimit);
      end
    end else if (clr_win) begin
      addr_d = 19'(cnt_q);
      we_d   = 1'b1;
      wd_d   = color_q;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    if ((state_q == StIdle) && bus.clear_start) begin
      state_d = StClear;
      color_d = bus.clear_color;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bus.vid_ack           = vid_win;
    bus.gl_ready          = gl_win;
    bus.vid_valid         = (tag2_q == TagVid);
    bus.gl_read_valid     = (tag2_q == TagGl);
    bus.vid_data          = (bus.vid_valid && !oor2_q) ? bus.ram_read_data : 3'b000;
    bus.gl_read_data      = (bus.gl_read_valid && !oor2_q) ? bus.ram_read_data : 3'b000;
    bus.clear_busy        = (state_q == StClear);
    bus.clear_done        = done_q;
    bus.ram_address       = addr_q;
    bus.ram_write_enabled = we_q;
    bus.ram_write_data    = wd_q;
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a registered-read RAM model.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_framebuffer_arbiter;

  localparam int unsigned PIXELS = 76800;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  framebuffer_arbiter_if bus ();

  framebuffer_arbiter #(
    .PIXELS          (PIXELS),
    .MAX_VIDEO_STREAK(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Out-of-range reads return 3'b111 so the arbiter's zero forcing is visible.
  logic [2:0] mem [PIXELS];
  always @(posedge clock) begin
    if (bus.ram_write_enabled && (bus.ram_address < 19'(PIXELS)))
      mem[bus.ram_address] <= bus.ram_write_data;
    bus.ram_read_data <= (bus.ram_address < 19'(PIXELS)) ? mem[bus.ram_address] : 3'b111;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.vid_ack, bus.gl_ready, bus.vid_valid, bus.gl_read_valid, bus.clear_busy,
                bus.clear_done, bus.ram_write_enabled, bus.ram_write_data, bus.ram_address}, 0);
    check({tag, "_data"}, {bus.vid_data, bus.gl_read_data}, 0);
  endtask

  logic [7:0] exp_ret [14];
  int         vcnt;
  int         errs;
  logic       exp_v;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.vid_req          = 1'b0;
    bus.vid_address      = '0;
    bus.gl_req           = 1'b0;
    bus.gl_write_enabled = 1'b0;
    bus.gl_address       = '0;
    bus.gl_write_data    = '0;
    bus.clear_start      = 1'b0;
    bus.clear_color      = '0;

    repeat (3) @(posedge clock);
    mid();
    check_all_zero("in_reset");
    step();
    reset = 1'b1;
    mid();
    check_all_zero("after_release");

    // Single game write, then command visible one cycle later.
    step();
    bus.gl_req = 1'b1; bus.gl_write_enabled = 1'b1; bus.gl_address = 19'd100;
    bus.gl_write_data = 3'b100;
    mid();
    check("gw_ready", {bus.gl_ready, bus.vid_ack}, 2'b10);
    step();
    bus.gl_req = 1'b0;
    mid();
    check("gw_cmd", {bus.ram_write_enabled, bus.ram_write_data, bus.ram_address},
          {1'b1, 3'b100, 19'd100});

    // Back-to-back writes: addr 5 = 010, addr 200+i = i.
    step();
    bus.gl_req = 1'b1; bus.gl_address = 19'd5; bus.gl_write_data = 3'b010;
    mid();
    check("gw5_ready", bus.gl_ready, 1);
    for (int i = 0; i < 9; i++) begin
      step();
      bus.gl_address = 19'(200 + i); bus.gl_write_data = 3'(i);
      mid();
      check("gw_burst_ready", bus.gl_ready, 1);
    end
    step();
    bus.gl_req = 1'b0;
    mid();
    check("gw_burst_last", {bus.ram_write_enabled, bus.ram_write_data, bus.ram_address},
          {1'b1, 3'd0, 19'd208});
    step();
    mid();
    check("no_grant_hold", {bus.ram_write_enabled, bus.ram_address}, {1'b0, 19'd208});

    // Game read of addr 5 returns 010 exactly two cycles after the grant.
    step();
    bus.gl_req = 1'b1; bus.gl_write_enabled = 1'b0; bus.gl_address = 19'd5;
    mid();
    check("gr_ready", bus.gl_ready, 1);
    step();
    bus.gl_req = 1'b0;
    mid();
    check("gr_cmd", {bus.ram_write_enabled, bus.ram_address, bus.gl_read_valid},
          {1'b0, 19'd5, 1'b0});
    step();
    mid();
    check("gr_return", {bus.gl_read_valid, bus.gl_read_data, bus.vid_valid}, {1'b1, 3'b010, 1'b0});
    step();
    mid();
    check("gr_pulse_once", bus.gl_read_valid, 0);

    // Continuous video + game: V,V,V,G repeating, reads return in order.
    vcnt = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (c < 12) begin
        bus.vid_req = 1'b1; bus.vid_address = 19'(200 + vcnt);
        bus.gl_req = 1'b1; bus.gl_write_enabled = 1'b0; bus.gl_address = 19'd5;
      end else begin
        bus.vid_req = 1'b0; bus.gl_req = 1'b0;
      end
      mid();
      exp_v = (c < 12) && ((c % 4) != 3);
      if (c < 12) begin
        check("streak_grant", {bus.vid_ack, bus.gl_ready}, exp_v ? 2'b10 : 2'b01);
        exp_ret[c] = exp_v ? {1'b1, 3'(vcnt), 1'b0, 3'b000} : {1'b0, 3'b000, 1'b1, 3'b010};
      end else begin
        exp_ret[c] = 8'h00;
      end
      if (c >= 2)
        check("streak_return", {bus.vid_valid, bus.vid_data, bus.gl_read_valid, bus.gl_read_data},
              exp_ret[c-2]);
      if (exp_v) vcnt++;
    end

    // Full clear with colour 0; game write held pending throughout.
    step();
    bus.clear_start = 1'b1; bus.clear_color = 3'b000;
    mid();
    check("clr_start_cycle", {bus.clear_busy, bus.ram_write_enabled}, 2'b00);
    step();
    bus.clear_start = 1'b0;
    bus.gl_req = 1'b1; bus.gl_write_enabled = 1'b1; bus.gl_address = 19'd300;
    bus.gl_write_data = 3'd5;
    errs = 0;
    for (int j = 1; j <= 76800; j++) begin
      mid();
      if (!(bus.clear_busy === 1'b1 && bus.gl_ready === 1'b0 && bus.clear_done === 1'b0)) errs++;
      if (j >= 2 && !(bus.ram_write_enabled === 1'b1 && bus.ram_address === 19'(j - 2) &&
                      bus.ram_write_data === 3'b000)) errs++;
      step();
    end
    mid();
    check("clear_seq_errs", errs, 0);
    check("clear_done_cycle", {bus.clear_done, bus.clear_busy, bus.gl_ready}, 3'b101);
    check("clear_last_write", {bus.ram_write_enabled, bus.ram_address}, {1'b1, 19'd76799});
    step();
    bus.gl_req = 1'b0;
    mid();
    check("clear_done_once", bus.clear_done, 0);
    check("gl_after_clear", {bus.ram_write_enabled, bus.ram_write_data, bus.ram_address},
          {1'b1, 3'd5, 19'd300});

    // Out-of-range write and read.
    step();
    bus.gl_req = 1'b1; bus.gl_write_enabled = 1'b1; bus.gl_address = 19'd76800;
    bus.gl_write_data = 3'd7;
    mid();
    check("oor_w_ready", bus.gl_ready, 1);
    step();
    bus.gl_req = 1'b0;
    mid();
    check("oor_w_we", bus.ram_write_enabled, 0);
    step();
    bus.gl_req = 1'b1; bus.gl_write_enabled = 1'b0; bus.gl_address = 19'd76800;
    mid();
    check("oor_r_ready", bus.gl_ready, 1);
    step();
    bus.gl_req = 1'b0;
    mid();
    step();
    mid();
    check("oor_r_return", {bus.gl_read_valid, bus.gl_read_data}, {1'b1, 3'b000});

    // Reset in the middle of a clear with a video read in flight.
    step();
    bus.clear_start = 1'b1; bus.clear_color = 3'b101;
    step();
    bus.clear_start = 1'b0;
    for (int j = 1; j < 4000; j++) step();
    bus.vid_req = 1'b1; bus.vid_address = 19'd201;
    mid();
    check("mc_busy_vack", {bus.clear_busy, bus.vid_ack}, 2'b11);
    step();
    bus.vid_req = 1'b0;
    mid();
    check("mc_vid_cmd", {bus.ram_write_enabled, bus.ram_address}, {1'b0, 19'd201});
    reset = 1'b0;
    #1;
    check_all_zero("mc_reset_now");
    step();
    mid();
    check("mc_no_valid", {bus.vid_valid, bus.vid_data}, 0);
    step();
    reset = 1'b1;
    mid();
    check("post_rst", {bus.clear_busy, bus.clear_done, bus.vid_valid, bus.ram_write_enabled}, 0);
    step();
    bus.gl_req = 1'b1; bus.gl_write_enabled = 1'b1; bus.gl_address = 19'd10;
    bus.gl_write_data = 3'd1;
    mid();
    check("post_rst_idle", {bus.gl_ready, bus.clear_busy}, 2'b10);
    step();
    bus.gl_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
